// File: rtl/csa_carry_resolver_if.sv
// Handshake bundle for the carry-save resolver. The producer side (master) drives
// the input pair and out_ready. The resolver (slave) drives ready, valid and the result.
interface csa_carry_resolver_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [1:0]       result_hi;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result, result_hi
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result, result_hi
    );
endinterface

// File: rtl/csa_carry_resolver.sv
// Slice-serial carry-propagate adder. It turns a carry-save (sum, carry) pair into
// binary: result = sum_in + 2*carry_in. One SLICE-wide chunk is resolved per cycle.
// Bits that overflow past WIDTH are kept in result_hi.
module csa_carry_resolver #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_carry_resolver_if.slave  bus,
    output logic                 busy
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // One slice of the ripple: SLICE-bit add with carry in, carry out on top
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cin_q, cin_d;
    logic               top_c_q, top_c_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         result_hi_q, result_hi_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [SLICE:0]     add;
    int                 base;

    // Next-state logic: accept in IDLE, resolve one slice per BUSY cycle, hold in DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cin_d       = cin_q;
        top_c_d     = top_c_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        base        = int'(cnt_q) * SLICE;
        add         = slice_add(a_q[base +: SLICE], b_q[base +: SLICE], cin_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // The carry vector has weight 2^(i+1). Its top bit falls outside
                    // WIDTH, so it is folded into result_hi at the end.
                    a_d        = bus.sum_in;
                    b_d        = {bus.carry_in[WIDTH-2:0], 1'b0};
                    top_c_d    = bus.carry_in[WIDTH-1];
                    cin_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            BUSY: begin
                result_d[base +: SLICE] = add[SLICE-1:0];
                cin_d = add[SLICE];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    result_hi_d = {1'b0, top_c_q} + {1'b0, add[SLICE]};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cin_q       <= 1'b0;
            top_c_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cin_q       <= cin_d;
            top_c_q     <= top_c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_csa_carry_resolver.sv
// Bench for csa_carry_resolver. It covers a table of directed and random vectors,
// a long output stall, and reset asserted mid-resolve.
// Expected results come from a full-width reference add and go through a scoreboard queue.
module tb_csa_carry_resolver;
    localparam int WIDTH  = 64;
    localparam int NSLICE = 4;

    typedef struct {
        logic [63:0] s;
        logic [63:0] c;
        logic [63:0] r;
        logic [1:0]  hi;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [65:0] sb_q[$];
    vec_t tbl[$];

    csa_carry_resolver_if #(.WIDTH(WIDTH)) bus ();

    csa_carry_resolver #(.WIDTH(WIDTH), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [65:0] model(input logic [63:0] s, input logic [63:0] c);
        return {2'b00, s} + {1'b0, c, 1'b0};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every accepted output against the oldest expected value
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", {bus.result_hi, bus.result}, 66'h0);
            end else begin
                check("sb_result", {bus.result_hi, bus.result}, sb_q.pop_front());
            end
        end
    end

    // Offer a pair once in_ready is high; returns #1 after the acceptance edge
    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [65:0] exp,
                        input bit push);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 66'(bus.in_ready), 66'h1);
        end else begin
            bus.sum_in   = s;
            bus.carry_in = c;
            bus.in_valid = 1'b1;
            if (push) sb_q.push_back(exp);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Count cycles from acceptance until out_valid rises
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [65:0] e;
        logic [63:0] rs, rc;

        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.carry_in  = '0;
        bus.out_ready = 1'b1;

        tbl.push_back('{64'h1, 64'h1, 64'h3, 2'd0});
        tbl.push_back('{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_8000, 64'h0000_0000_0001_FFFF, 2'd0});
        tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 2'd2});
        tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 2'd1});
        tbl.push_back('{64'h0, 64'h8000_0000_0000_0000, 64'h0, 2'd1});
        tbl.push_back('{64'h0, 64'h0, 64'h0, 2'd0});
        for (int i = 0; i < 8; i++) begin
            rs = {$urandom, $urandom};
            rc = {$urandom, $urandom};
            e  = model(rs, rc);
            tbl.push_back('{rs, rc, e[63:0], e[65:64]});
        end

        // Reset state
        #12;
        check("rst_in_ready",  66'(bus.in_ready), 66'h1);
        check("rst_out_valid", 66'(bus.out_valid), 66'h0);
        check("rst_busy",      66'(busy), 66'h0);
        check("rst_result",    {bus.result_hi, bus.result}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].s, tbl[i].c, {tbl[i].hi, tbl[i].r}, 1'b1);
            check("busy_after_accept", 66'(busy), 66'h1);
            wait_valid(lat);
            check("latency", 66'(lat), 66'(NSLICE));
        end

        // Stall in DONE: output held, in_ready low, extra in_valid ignored
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, e, 1'b1);
        wait_valid(lat);
        check("stall_latency", 66'(lat), 66'(NSLICE));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.sum_in   = 64'hDEAD;
                bus.carry_in = 64'hBEEF;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check("stall_result", {bus.result_hi, bus.result}, e);
            check("stall_in_ready", 66'(bus.in_ready), 66'h0);
            check("stall_out_valid", 66'(bus.out_valid), 66'h1);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 66'(bus.out_valid), 66'h0);
        check("release_in_ready",  66'(bus.in_ready), 66'h1);
        repeat (8) @(posedge clk);
        #1;
        check("ignored_pulse_no_output", 66'(bus.out_valid), 66'h0);
        check("ignored_pulse_idle", 66'(busy), 66'h0);

        // Reset during slice 2; the in-flight operation must vanish
        send(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 66'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 66'(busy), 66'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  66'(bus.in_ready), 66'h1);
        check("mid_rst_out_valid", 66'(bus.out_valid), 66'h0);
        check("mid_rst_busy",      66'(busy), 66'h0);
        check("mid_rst_result",    {bus.result_hi, bus.result}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(64'h5, 64'h2, 66'h9, 1'b1);
        wait_valid(lat);
        check("post_rst_latency", 66'(lat), 66'(NSLICE));
        @(negedge clk);
        check("post_rst_result", {bus.result_hi, bus.result}, 66'h9);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 66'(sb_q.size()), 66'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_carry_resolver.md
Name: csa_carry_resolver

Overview:
- Consumes the redundant (sum, carry) vector pair produced by the 64-bit carry-save full-adder layer.
- Resolves the pair into a plain binary value: result = sum_in + (carry_in << 1).
- Multi-cycle, slice-serial carry-propagate adder with valid/ready handshakes on both sides. It sits between the carry-save accumulation stage and any consumer that needs a binary generator state.

Parameters:
WIDTH, 64, operand width of sum_in/carry_in/result
SLICE, 16, bits resolved per cycle; WIDTH must be an integer multiple of SLICE
NSLICE, WIDTH/SLICE (derived, localparam), number of resolve cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sum_in/carry_in valid
in_ready  output  1  block can accept a new pair
sum_in  input  WIDTH  per-bit sum vector (Si1 from full-adder layer)
carry_in  input  WIDTH  per-bit carry vector (cyi), weight 2^(i+1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  low WIDTH bits of sum_in + 2*carry_in
result_hi  output  2  bits WIDTH+1..WIDTH of the full sum (max value 2)
busy  output  1  resolve in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, result_hi=0, state=IDLE, slice counter=0, internal carry=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_reg=sum_in and b_reg={carry_in[WIDTH-2:0],1'b0}.
  - Latch top_c=carry_in[WIDTH-1]. Clear cin and counter. Go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle k (0..NSLICE-1) computes {c,s} = a_reg[k-th slice] + b_reg[k-th slice] + cin (SLICE+1 bits).
  - Writes s into result[k-th slice], sets cin=c, and increments the counter.
  - After slice NSLICE-1, go to DONE. result_hi = top_c + cin, a 2-bit zero-extended add.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - result and result_hi are held stable while out_valid&&!out_ready.
  - On out_ready: out_valid falls next cycle, return to IDLE, in_ready=1 next cycle.
- Latency:
  - Acceptance edge T0; out_valid high from edge T0+NSLICE (4 cycles at defaults).
  - Minimum issue interval is NSLICE+2 cycles, because there is no acceptance in DONE.
- Partial results: result bits of slices not yet resolved are don't-care while busy. They may hold stale values. The bench checks only when out_valid=1.
- Arithmetic: full-width modular add with no saturation. Every carry, including the one out of the top slice, is preserved in result_hi.
- Input sampling: sum_in/carry_in are sampled only at the acceptance edge. Changes to inputs while BUSY/DONE have no effect. in_valid while not ready is ignored, not queued.
- Reset mid-operation: rst_n low at any time immediately returns all state and outputs to reset values. The in-flight operation is discarded with no output.
- out_ready high before DONE has no effect and is not remembered.

Test Plan:
- sum_in=64'h1, carry_in=64'h1 -> after 4 cycles out_valid=1, result=64'h3, result_hi=0.
- sum_in=64'h0000_0000_0000_FFFF, carry_in=64'h0000_0000_0000_8000 -> result=64'h0000_0000_0001_FFFF; checks the cross-slice carry.
- sum_in=all ones, carry_in=all ones -> result=64'hFFFF_FFFF_FFFF_FFFD, result_hi=2'b10 (3*2^64-3).
- sum_in=all ones, carry_in=64'h0...01 -> result=64'h1, result_hi=2'b01; checks carry ripple through all four slices.
- out_ready held low 10 cycles in DONE -> result stable, in_ready=0, and a second in_valid pulse is ignored. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- rst_n pulsed low during BUSY slice 2 -> all outputs zero and in_ready=1 immediately. A following op sum_in=64'h5, carry_in=64'h2 gives result=64'h9.
